// File: rtl/alu_seq_if.sv
// Operand/result bus between the register file side and the sequential ALU.
// The master drives the request; the slave (ALU) returns the registered result and flags.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic [7:0]           instruction;
  logic [WIDTH-1:0]     op1;
  logic [WIDTH-1:0]     op2;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   out;
  logic                 carry_flag;
  logic                 parity_flag;
  logic                 eq_flag;
  logic                 gt_flag;

  modport master (
    output start, instruction, op1, op2,
    input  busy, done, out, carry_flag, parity_flag, eq_flag, gt_flag
  );

  modport slave (
    input  start, instruction, op1, op2,
    output busy, done, out, carry_flag, parity_flag, eq_flag, gt_flag
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle logic/arithmetic ops plus a WIDTH-cycle shift-add
// multiplier. Results and flags hold until the next accepted operation.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [7:0] OP_ADD = 8'h01, OP_SUB = 8'h02, OP_MUL = 8'h03,
                         OP_AND = 8'h04, OP_OR  = 8'h05, OP_XOR = 8'h06,
                         OP_INC = 8'h07, OP_DEC = 8'h08, OP_ROR = 8'h09,
                         OP_ROL = 8'h0A, OP_RSH = 8'h0B, OP_LSH = 8'h0C,
                         OP_NOT = 8'h0D;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               carry_q, carry_d, parity_q, parity_d;
  logic               eq_q, eq_d, gt_q, gt_d;
  logic [2*WIDTH-1:0] out_q, out_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, partial_q, partial_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   a, b, res;
  logic [WIDTH:0]     add_w;
  logic [2*WIDTH-1:0] acc;
  logic               res_vld;

  assign a     = bus.op1;
  assign b     = bus.op2;
  assign add_w = {1'b0, a} + {1'b0, b};
  // Partial product after this step: add the shifted multiplicand when the multiplier LSB is set.
  assign acc   = partial_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    carry_d   = carry_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    out_d     = out_q;
    mcand_d   = mcand_q;
    partial_d = partial_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    res       = '0;
    res_vld   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          eq_d   = (a == b);
          gt_d   = (a > b);
          done_d = 1'b1;
          case (bus.instruction)
            OP_ADD: begin res = add_w[WIDTH-1:0]; carry_d = add_w[WIDTH]; res_vld = 1'b1; end
            OP_SUB: begin res = a - b; carry_d = (a < b); res_vld = 1'b1; end
            OP_MUL: begin
              state_d   = S_MUL;
              busy_d    = 1'b1;
              done_d    = 1'b0;
              cnt_d     = CW'(WIDTH);
              partial_d = '0;
              mcand_d   = {{WIDTH{1'b0}}, a};
              mplier_d  = b;
            end
            OP_AND: begin res = a & b; res_vld = 1'b1; end
            OP_OR:  begin res = a | b; res_vld = 1'b1; end
            OP_XOR: begin res = a ^ b; res_vld = 1'b1; end
            OP_INC: begin res = a + 1'b1; res_vld = 1'b1; end
            OP_DEC: begin res = a - 1'b1; res_vld = 1'b1; end
            OP_ROR: begin res = {a[0], a[WIDTH-1:1]}; carry_d = a[0]; res_vld = 1'b1; end
            OP_ROL: begin res = {a[WIDTH-2:0], a[WIDTH-1]}; carry_d = a[WIDTH-1]; res_vld = 1'b1; end
            OP_RSH: begin res = {1'b0, a[WIDTH-1:1]}; carry_d = a[0]; res_vld = 1'b1; end
            OP_LSH: begin res = {a[WIDTH-2:0], 1'b0}; carry_d = a[WIDTH-1]; res_vld = 1'b1; end
            OP_NOT: begin res = ~a; res_vld = 1'b1; end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        partial_d = acc;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          out_d   = acc;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (res_vld) out_d = {{WIDTH{1'b0}}, res};
    parity_d = ^out_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      carry_q   <= 1'b0;
      parity_q  <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      out_q     <= '0;
      mcand_q   <= '0;
      partial_q <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      carry_q   <= carry_d;
      parity_q  <= parity_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      out_q     <= out_d;
      mcand_q   <= mcand_d;
      partial_q <= partial_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.out         = out_q;
  assign bus.carry_flag  = carry_q;
  assign bus.parity_flag = parity_q;
  assign bus.eq_flag     = eq_q;
  assign bus.gt_flag     = gt_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8 and WIDTH=16: an arithmetic reference model
// predicts each response at issue time; a monitor matches it against done pulses.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  b8 ();
  alu_seq_if #(.WIDTH(16)) b16 ();
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  typedef struct {
    int          cyc;
    logic [63:0] out;
    logic        c, p, eq, gt;
  } exp_t;

  exp_t        q8[$];
  exp_t        q16[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          busy_until[2];
  logic [63:0] m_out[2];
  logic        m_c[2];
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wof(int id);
    return (id == 0) ? 8 : 16;
  endfunction

  task automatic chk(string name, int id, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s w=%0d cyc=%0d actual=%h expected=%h", name, wof(id), cyc, act, exp);
    end
  endtask

  task automatic drive(int id, logic s, logic [7:0] ins, logic [63:0] a, logic [63:0] b);
    if (id == 0) begin
      b8.start = s; b8.instruction = ins; b8.op1 = a[7:0]; b8.op2 = b[7:0];
    end else begin
      b16.start = s; b16.instruction = ins; b16.op1 = a[15:0]; b16.op2 = b[15:0];
    end
  endtask

  // f = {busy, done, carry, parity, eq, gt}
  task automatic sample(int id, output logic [63:0] o, output logic [5:0] f);
    if (id == 0) begin
      o = {56'd0, b8.out};
      f = {b8.busy, b8.done, b8.carry_flag, b8.parity_flag, b8.eq_flag, b8.gt_flag};
    end else begin
      o = {32'd0, b16.out};
      f = {b16.busy, b16.done, b16.carry_flag, b16.parity_flag, b16.eq_flag, b16.gt_flag};
    end
  endtask

  task automatic do_reset();
    logic [63:0] o;
    logic [5:0]  f;
    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 0, 0);
    drive(1, 1'b0, 8'h00, 0, 0);
    q8.delete();
    q16.delete();
    for (int i = 0; i < 2; i++) begin
      busy_until[i] = 0; m_out[i] = 64'd0; m_c[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int id = 0; id < 2; id++) begin
      sample(id, o, f);
      chk("reset_out", id, o, 64'd0);
      chk("reset_flags", id, {58'd0, f}, 64'd0);
    end
  endtask

  // Called at a negedge. Waits (optionally driving junk starts) until the model says the
  // DUT is idle, then issues the op and records its predicted response.
  task automatic run_op(int id, logic [7:0] ins, logic [63:0] a_in, logic [63:0] b_in, int junk);
    int          w = wof(id);
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    logic [63:0] a = a_in & mask;
    logic [63:0] b = b_in & mask;
    exp_t        e;
    int          lat = 1;
    while (cyc < busy_until[id]) begin
      drive(id, (junk == 2) ? 1'b1 : (junk == 1) ? 1'($urandom_range(0, 1)) : 1'b0,
            8'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      @(negedge clk);
    end
    e.out = m_out[id];
    e.c   = m_c[id];
    case (ins)
      8'h01: begin e.out = (a + b) & mask; e.c = ((a + b) >> w) != 0; end
      8'h02: begin e.out = (a - b) & mask; e.c = (a < b); end
      8'h03: begin e.out = a * b; lat = w + 1; end
      8'h04: e.out = a & b;
      8'h05: e.out = a | b;
      8'h06: e.out = a ^ b;
      8'h07: e.out = (a + 1) & mask;
      8'h08: e.out = (a - 1) & mask;
      8'h09: begin e.out = (a >> 1) | ((a & 1) << (w - 1)); e.c = a[0]; end
      8'h0A: begin e.out = ((a << 1) | (a >> (w - 1))) & mask; e.c = a[w-1]; end
      8'h0B: begin e.out = a >> 1; e.c = a[0]; end
      8'h0C: begin e.out = (a << 1) & mask; e.c = a[w-1]; end
      8'h0D: e.out = ~a & mask;
      default: ;
    endcase
    e.p   = ^e.out;
    e.eq  = (a == b);
    e.gt  = (a > b);
    e.cyc = cyc + lat;
    m_out[id]      = e.out;
    m_c[id]        = e.c;
    busy_until[id] = e.cyc;
    if (id == 0) q8.push_back(e); else q16.push_back(e);
    drive(id, 1'b1, ins, a, b);
    @(negedge clk);
    drive(id, 1'b0, 8'h00, 0, 0);
  endtask

  task automatic check_dut(int id);
    logic [63:0] o;
    logic [5:0]  f;
    exp_t        e;
    bit          have;
    sample(id, o, f);
    chk("busy", id, {63'd0, f[5]}, {63'd0, (cyc < busy_until[id])});
    have = (id == 0) ? (q8.size() > 0) : (q16.size() > 0);
    if (have) begin
      if (id == 0) e = q8[0]; else e = q16[0];
    end
    if (f[4] === 1'b1) begin
      if (!have || e.cyc != cyc) begin
        checks++; failures++;
        $display("FAIL unexpected_done w=%0d cyc=%0d actual=1 expected=0", wof(id), cyc);
      end else begin
        if (id == 0) void'(q8.pop_front()); else void'(q16.pop_front());
        chk("out", id, o, e.out);
        chk("carry", id, {63'd0, f[3]}, {63'd0, e.c});
        chk("parity", id, {63'd0, f[2]}, {63'd0, e.p});
        chk("eq", id, {63'd0, f[1]}, {63'd0, e.eq});
        chk("gt", id, {63'd0, f[0]}, {63'd0, e.gt});
      end
    end else if (have && e.cyc <= cyc) begin
      checks++; failures++;
      $display("FAIL missing_done w=%0d cyc=%0d actual=0 expected=1", wof(id), cyc);
      if (id == 0) void'(q8.pop_front()); else void'(q16.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        for (int id = 0; id < 2; id++) check_dut(id);
      end
    end
  end

  task automatic directed(int id);
    int          w = wof(id);
    logic [63:0] mx = (64'd1 << w) - 64'd1;
    logic [63:0] top = 64'd1 << (w - 1);
    do_reset();
    if (w == 8) run_op(id, 8'h01, 64'hF0, 64'h20, 0);
    else        run_op(id, 8'h01, mx - 64'hF, 64'h20, 0);
    run_op(id, 8'h02, 64'h05, 64'h07, 0);
    run_op(id, 8'h07, mx, 64'h00, 0);
    run_op(id, 8'h03, mx, mx, 2);
    run_op(id, 8'h01, 64'h3, 64'h4, 2);
    run_op(id, 8'h09, top | 64'd1, 0, 0);
    run_op(id, 8'h0A, top | 64'd1, 0, 0);
    run_op(id, 8'h0B, top | 64'd1, 0, 0);
    run_op(id, 8'h0C, top | 64'd1, 0, 0);
    run_op(id, 8'h0B, mx - top - 64'd1, 0, 0);
    run_op(id, 8'h08, 64'h0, 64'h0, 0);
    run_op(id, 8'h03, 64'h12, 64'h34, 0);
    @(negedge clk);
    do_reset();
    repeat (w + 3) @(negedge clk);
    run_op(id, 8'h03, 64'h12, 64'h34, 0);
    run_op(id, 8'h04, 64'h33, 64'h11, 0);
    run_op(id, 8'h00, 64'h33, 64'h33, 0);
    run_op(id, 8'hEE, 64'h33, 64'h33, 0);
  endtask

  task automatic random_ops(int id, int n);
    logic [7:0]  ins;
    logic [63:0] a, b;
    for (int i = 0; i < n; i++) begin
      ins = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 13));
      case ($urandom_range(0, 3))
        0: a = 64'd0;
        1: a = 64'hFFFF_FFFF_FFFF_FFFF;
        default: a = {$urandom, $urandom};
      endcase
      b = ($urandom_range(0, 4) == 0) ? a : {$urandom, $urandom};
      run_op(id, ins, a, b, 1);
    end
  endtask

  initial begin
    drive(0, 1'b0, 8'h00, 0, 0);
    drive(1, 1'b0, 8'h00, 0, 0);
    repeat (2) @(negedge clk);
    do_reset();
    mon_en = 1'b1;
    directed(0);
    random_ops(0, 200);
    directed(1);
    random_ops(1, 200);
    repeat (20) @(negedge clk);
    if (q8.size() != 0 || q16.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain actual=%0d expected=0", q8.size() + q16.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
